imem_responder: RTL and testbench

// Instruction-memory responder serving the fetch stage: it answers IMEM_Addr with IMEM_Dout.
// - Fetch side: answers in the same cycle, with a combinational read of a register array.
//   The fetch stage latches IR on the same edge at which it presents PC, so there is no added latency.
// - Load side: a valid/ready loader port writes program words through a small FSM.
// - Until a load completes, the block returns NOP (32'h0) and raises IMEM_busy.
// - Drives IMEM_Base_Addr and IMEM_High_Addr so that fetch range checks match the array.

---
 rtl/imem_responder.sv | 125 ++++++++++++
 tb/tb_imem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory with a same-cycle combinational fetch port and a valid/ready program loader.
// Fetches return NOP until a load has completed.
module imem_responder #(
   parameter int unsigned DEPTH      = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int unsigned ADDR_SHIFT = 2,
   localparam int unsigned AW        = $clog2(DEPTH),
   localparam int unsigned CW        = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   IMEM_Addr,
   output logic [31:0]   IMEM_Dout,
   output logic [31:0]   IMEM_Base_Addr,
   output logic [31:0]   IMEM_High_Addr,
   output logic          IMEM_busy,
   output logic          IMEM_oor,
   input  logic          LD_start,
   input  logic [CW-1:0] LD_count,
   input  logic          LD_valid,
   input  logic [31:0]   LD_data,
   output logic          LD_ready,
   output logic          LD_done,
   output logic          LD_err,
   output logic [31:0]   LD_checksum
);

   localparam logic [31:0]   SPAN_LAST = 32'(DEPTH << ADDR_SHIFT) - 32'd1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] remaining_q, remaining_d;
   logic [31:0]   checksum_q, checksum_d;
   logic          err_q, err_d;
   logic          done_q, done_d;
   logic          count_legal;
   logic          accept;

   logic [31:0]   mem [DEPTH];

   logic [31:0]   fetch_off;
   logic [AW-1:0] fetch_idx;
   logic          fetch_in_range;

   always_comb begin
      count_legal = (LD_count != '0) && (LD_count <= MAX_COUNT);
      // A start pulse takes priority over a word offered in the same cycle.
      accept      = (state_q == StLoad) && LD_valid && !LD_start;
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      remaining_d = remaining_q;
      checksum_d  = checksum_q;
      err_d       = err_q;
      done_d      = 1'b0;
      if (LD_start) begin
         if (count_legal) begin
            state_d     = StLoad;
            wr_ptr_d    = '0;
            remaining_d = LD_count;
            checksum_d  = '0;
            err_d       = 1'b0;
         end else begin
            err_d = 1'b1;
            if (state_q == StLoad) begin
               state_d     = StIdle;
               remaining_d = '0;
            end
         end
      end else if (accept) begin
         wr_ptr_d    = wr_ptr_q + AW'(1);
         remaining_d = remaining_q - CW'(1);
         checksum_d  = checksum_q ^ LD_data;
         if (remaining_q == CW'(1)) begin
            state_d = StReady;
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         remaining_q <= '0;
         checksum_q  <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         remaining_q <= remaining_d;
         checksum_q  <= checksum_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   // Contents survive reset so a program can be kept across a core reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_q] <= LD_data;
      end
   end

   // Addresses below the base wrap to a large offset and fall out of range.
   always_comb begin
      fetch_off      = IMEM_Addr - BASE_ADDR;
      fetch_idx      = AW'(fetch_off >> ADDR_SHIFT);
      fetch_in_range = (fetch_off <= SPAN_LAST);
   end

   assign IMEM_Dout      = ((state_q == StReady) && fetch_in_range) ? mem[fetch_idx] : 32'h0;
   assign IMEM_oor       = (state_q == StReady) && !fetch_in_range;
   assign IMEM_busy      = (state_q != StReady);
   assign IMEM_Base_Addr = BASE_ADDR;
   assign IMEM_High_Addr = BASE_ADDR + SPAN_LAST;
   assign LD_ready       = (state_q == StLoad);
   assign LD_done        = done_q;
   assign LD_err         = err_q;
   assign LD_checksum    = checksum_q;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized scoreboard bench for imem_responder against a transaction-level load/fetch model.
module tb_imem_responder;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h100;
   localparam int unsigned SHIFT = 2;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam logic [31:0] HIGH  = BASE + (DEPTH << SHIFT) - 1;

   logic          clk;
   logic          rst;
   logic [31:0]   IMEM_Addr;
   logic [31:0]   IMEM_Dout;
   logic [31:0]   IMEM_Base_Addr;
   logic [31:0]   IMEM_High_Addr;
   logic          IMEM_busy;
   logic          IMEM_oor;
   logic          LD_start;
   logic [CW-1:0] LD_count;
   logic          LD_valid;
   logic [31:0]   LD_data;
   logic          LD_ready;
   logic          LD_done;
   logic          LD_err;
   logic [31:0]   LD_checksum;

   imem_responder #(
      .DEPTH(DEPTH),
      .BASE_ADDR(BASE),
      .ADDR_SHIFT(SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .IMEM_Addr(IMEM_Addr),
      .IMEM_Dout(IMEM_Dout),
      .IMEM_Base_Addr(IMEM_Base_Addr),
      .IMEM_High_Addr(IMEM_High_Addr),
      .IMEM_busy(IMEM_busy),
      .IMEM_oor(IMEM_oor),
      .LD_start(LD_start),
      .LD_count(LD_count),
      .LD_valid(LD_valid),
      .LD_data(LD_data),
      .LD_ready(LD_ready),
      .LD_done(LD_done),
      .LD_err(LD_err),
      .LD_checksum(LD_checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] dout;
      logic        oor;
      logic        busy;
      logic        rdy;
      logic        err;
      logic [31:0] csum;
   } exp_t;

   exp_t  chk_q[$];
   int    done_q[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc_n       = 0;

   // Reference model: 0 = no program, 1 = loading, 2 = program loaded.
   int          m_mode;
   int          m_ptr;
   int          m_rem;
   logic [31:0] m_csum;
   logic        m_err;
   logic [31:0] m_mem [DEPTH];

   function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t r;
      int   d;
      if (chk_q.size() > 0) begin
         r = chk_q.pop_front();
         check32("dout", IMEM_Dout, r.dout);
         check32("oor", 32'(IMEM_oor), 32'(r.oor));
         check32("busy", 32'(IMEM_busy), 32'(r.busy));
         check32("ld_ready", 32'(LD_ready), 32'(r.rdy));
         check32("ld_err", 32'(LD_err), 32'(r.err));
         check32("checksum", LD_checksum, r.csum);
         check32("base", IMEM_Base_Addr, BASE);
         check32("high", IMEM_High_Addr, HIGH);
      end
      if (!rst) begin
         if (done_q.size() > 0 && done_q[0] == cyc_n) begin
            d = done_q.pop_front();
            check32("ld_done", 32'(LD_done), 32'd1);
         end else begin
            check32("ld_done_idle", 32'(LD_done), 32'd0);
         end
         while (done_q.size() > 0 && done_q[0] < cyc_n) begin
            d = done_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL ld_done_missed: expected at cycle %0d, got none", d);
         end
      end
   end

   task automatic cyc(input logic start, input int count, input logic valid,
                      input logic [31:0] data, input logic [31:0] addr);
      exp_t        e;
      logic [31:0] off;
      logic        inr;
      LD_start  = start;
      LD_count  = CW'(count);
      LD_valid  = valid;
      LD_data   = data;
      IMEM_Addr = addr;
      off    = addr - BASE;
      inr    = (off < (DEPTH << SHIFT));
      e.busy = (m_mode != 2);
      e.rdy  = (m_mode == 1);
      e.err  = m_err;
      e.csum = m_csum;
      e.oor  = (m_mode == 2) && !inr;
      e.dout = ((m_mode == 2) && inr) ? m_mem[(off >> SHIFT) % DEPTH] : 32'h0;
      chk_q.push_back(e);
      @(posedge clk);
      cyc_n++;
      if (start) begin
         if (count >= 1 && count <= DEPTH) begin
            m_mode = 1;
            m_ptr  = 0;
            m_rem  = count;
            m_csum = 32'h0;
            m_err  = 1'b0;
         end else begin
            m_err = 1'b1;
            if (m_mode == 1) m_mode = 0;
         end
      end else if (m_mode == 1 && valid) begin
         m_mem[m_ptr] = data;
         m_csum       = m_csum ^ data;
         m_ptr        = (m_ptr + 1) % DEPTH;
         m_rem        = m_rem - 1;
         if (m_rem == 0) begin
            m_mode = 2;
            done_q.push_back(cyc_n);
         end
      end
      #1;
   endtask

   task automatic idle(input logic [31:0] addr);
      cyc(1'b0, 0, 1'b0, 32'h0, addr);
   endtask

   function automatic logic [31:0] rand_addr();
      return BASE - 32'd8 + 32'($urandom_range(0, DEPTH * 4 + 15));
   endfunction

   task automatic do_reset();
      exp_t e;
      LD_start = 1'b0;
      LD_valid = 1'b0;
      rst      = 1'b1;
      m_mode   = 0;
      m_ptr    = 0;
      m_rem    = 0;
      m_csum   = 32'h0;
      m_err    = 1'b0;
      done_q.delete();
      e.dout = 32'h0;
      e.oor  = 1'b0;
      e.busy = 1'b1;
      e.rdy  = 1'b0;
      e.err  = 1'b0;
      e.csum = 32'h0;
      chk_q.push_back(e);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] w4 [4];
      w4[0] = 32'h11;
      w4[1] = 32'h22;
      w4[2] = 32'h33;
      w4[3] = 32'h44;
      IMEM_Addr = BASE;
      LD_count  = '0;
      LD_data   = '0;
      do_reset();
      repeat (3) idle(rand_addr());

      // Fill the whole array so every later fetch has a defined expectation.
      cyc(1'b1, DEPTH, 1'b0, 32'h0, BASE);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 0, 1'b1, $urandom, rand_addr());
      repeat (20) idle(rand_addr());

      cyc(1'b1, 4, 1'b0, 32'h0, BASE);
      for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, w4[i], BASE + 8);
      idle(BASE + 8);
      idle(HIGH + 1);
      idle(HIGH);
      idle(BASE - 4);
      idle(BASE + 3);

      cyc(1'b1, 0, 1'b0, 32'h0, BASE + 8);
      idle(BASE + 4);
      cyc(1'b1, DEPTH + 1, 1'b0, 32'h0, BASE + 12);
      idle(BASE + 8);
      cyc(1'b1, 2, 1'b0, 32'h0, BASE);
      cyc(1'b0, 0, 1'b1, 32'hA1, BASE);
      cyc(1'b0, 0, 1'b1, 32'hA2, BASE);
      idle(BASE + 4);

      cyc(1'b1, 5, 1'b0, 32'h0, BASE);
      cyc(1'b0, 0, 1'b1, 32'hB1, BASE);
      cyc(1'b0, 0, 1'b1, 32'hB2, BASE);
      cyc(1'b1, 3, 1'b1, 32'hDEAD, BASE);
      for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 32'hC0 + i, BASE + 4 * i);
      idle(BASE + 4);
      idle(BASE + 8);

      cyc(1'b1, 2, 1'b0, 32'h0, BASE);
      cyc(1'b0, 0, 1'b1, 32'hD1, BASE);
      cyc(1'b0, 0, 1'b0, 32'hFF, BASE);
      cyc(1'b0, 0, 1'b1, 32'hD2, BASE);
      cyc(1'b0, 0, 1'b0, 32'hFE, BASE);
      idle(BASE);
      idle(BASE + 4);

      do_reset();
      idle(BASE + 8);
      cyc(1'b1, 1, 1'b0, 32'h0, BASE);
      cyc(1'b0, 0, 1'b1, 32'hE0, BASE);
      for (int i = 0; i < DEPTH; i++) idle(BASE + 4 * i);

      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 12) == 0, $urandom_range(0, DEPTH + 1), ($urandom % 3) != 0,
             $urandom, rand_addr());
      end
      repeat (3) idle(rand_addr());
      @(negedge clk);
      #1;
      check32("done_queue_drained", 32'(done_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
